// File: rtl/if_fetch.sv
// Instruction-fetch stage: keeps the fetch PC, issues single-outstanding word reads
// to instruction memory and buffers returned words in a small FIFO toward ID.
module if_fetch #(
    parameter logic [31:0] PC_RESET    = 32'h0000_0000,
    parameter int          QUEUE_DEPTH = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        Redirect,
    input  logic [31:0] RedirectPC,
    output logic        ImemReq,
    output logic [31:0] ImemAddr,
    input  logic        ImemAck,
    input  logic [31:0] ImemData,
    output logic        InsValid,
    input  logic        InsReady,
    output logic [31:0] Ins,
    output logic [31:0] InsPC,
    output logic [31:0] PCPlus4
);

    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(QUEUE_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PEND = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [31:0]      req_pc_q, req_pc_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [31:0]      q_pc_q  [QUEUE_DEPTH];
    logic [31:0]      q_ins_q [QUEUE_DEPTH];

    logic             push;
    logic             pop;
    logic [CNT_W-1:0] cnt_after;
    logic             space;
    logic [31:0]      pc_next;

    assign ImemReq  = (state_q == S_PEND) || (state_q == S_DROP);
    assign ImemAddr = req_pc_q;

    assign InsValid = (count_q != '0);
    assign Ins      = InsValid ? q_ins_q[rd_ptr_q] : 32'd0;
    assign InsPC    = InsValid ? q_pc_q[rd_ptr_q] : 32'd0;
    assign PCPlus4  = InsValid ? (q_pc_q[rd_ptr_q] + 32'd4) : 32'd0;

    // Only a live (non-redirected) ack in PEND carries a word for the queue.
    assign push      = (state_q == S_PEND) && ImemAck && !Redirect;
    assign pop       = InsValid && InsReady;
    assign cnt_after = count_q - CNT_W'(pop) + CNT_W'(push);
    assign space     = (cnt_after < DEPTH_C);
    assign pc_next   = req_pc_q + 32'd4;

    assign count_d  = Redirect ? '0 : cnt_after;
    assign rd_ptr_d = Redirect ? '0 : (rd_ptr_q + PTR_W'(pop));
    assign wr_ptr_d = Redirect ? '0 : (wr_ptr_q + PTR_W'(push));

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        case (state_q)
            S_IDLE: begin
                if (Redirect) begin
                    fetch_pc_d = RedirectPC;
                end else if (count_q < DEPTH_C) begin
                    req_pc_d = fetch_pc_q;
                    state_d  = S_PEND;
                end
            end
            S_PEND: begin
                if (Redirect) begin
                    fetch_pc_d = RedirectPC;
                    if (ImemAck) req_pc_d = RedirectPC;
                    else         state_d  = S_DROP;
                end else if (ImemAck) begin
                    fetch_pc_d = pc_next;
                    if (space) req_pc_d = pc_next;
                    else       state_d  = S_IDLE;
                end
            end
            S_DROP: begin
                // The stale request must complete before the new address is issued.
                if (Redirect) fetch_pc_d = RedirectPC;
                if (ImemAck) begin
                    req_pc_d = Redirect ? RedirectPC : fetch_pc_q;
                    state_d  = S_PEND;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= PC_RESET;
            req_pc_q   <= 32'd0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            q_pc_q[wr_ptr_q]  <= req_pc_q;
            q_ins_q[wr_ptr_q] <= ImemData;
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed reset/latency/redirect steps followed by randomized traffic,
// with a scoreboard that expects a sequential PC stream restarted at every redirect.
module tb_if_fetch;

    logic        CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        RST, Redirect, ImemAck, InsReady;
    logic [31:0] RedirectPC, ImemData;
    logic        ImemReq, InsValid;
    logic [31:0] ImemAddr, Ins, InsPC, PCPlus4;

    logic        InsReady_w;
    logic        ImemReq_w, InsValid_w, ImemAck_w;
    logic [31:0] ImemAddr_w, ImemData_w, Ins_w, InsPC_w, PCPlus4_w;

    int          checks = 0;
    int          failures = 0;
    int          lat_left = -1;
    int          fixed_lat = 0;
    bit          ack_override = 1'b0;
    bit          rand_mode = 1'b0;
    int          delivered = 0;
    int          d0;
    logic [31:0] exp_pc, exp_w, prev_addr, rpc;
    logic        prev_req, prev_ack;

    function automatic logic [31:0] ref_word(input logic [31:0] pc);
        return (pc * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    if_fetch u_a (
        .CLK(CLK), .RST(RST), .Redirect(Redirect), .RedirectPC(RedirectPC),
        .ImemReq(ImemReq), .ImemAddr(ImemAddr), .ImemAck(ImemAck), .ImemData(ImemData),
        .InsValid(InsValid), .InsReady(InsReady), .Ins(Ins), .InsPC(InsPC), .PCPlus4(PCPlus4)
    );

    // Second instance: wrap-around reset PC, deeper queue, single-cycle memory, no redirects.
    assign ImemAck_w  = ImemReq_w;
    assign ImemData_w = ref_word(ImemAddr_w);

    if_fetch #(.PC_RESET(32'hFFFF_FFF8), .QUEUE_DEPTH(4)) u_w (
        .CLK(CLK), .RST(RST), .Redirect(1'b0), .RedirectPC(32'd0),
        .ImemReq(ImemReq_w), .ImemAddr(ImemAddr_w), .ImemAck(ImemAck_w), .ImemData(ImemData_w),
        .InsValid(InsValid_w), .InsReady(InsReady_w), .Ins(Ins_w), .InsPC(InsPC_w),
        .PCPlus4(PCPlus4_w)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs and the memory model at the falling edge, then check.
    task automatic cyc(input logic rdy, input logic redir, input logic [31:0] tgt);
        @(negedge CLK);
        InsReady   = rdy;
        Redirect   = redir;
        RedirectPC = tgt;
        InsReady_w = rand_mode ? (($urandom % 2) != 0) : 1'b1;
        if (ack_override) begin
            ImemAck  = 1'b1;
            ImemData = 32'hDEAD_BEEF;
        end else if (!ImemReq) begin
            ImemAck  = rand_mode && (($urandom % 3) == 0);
            ImemData = $urandom;
            lat_left = -1;
        end else begin
            if (lat_left < 0) lat_left = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(3, 0));
            if (lat_left == 0) begin
                ImemAck  = 1'b1;
                ImemData = ref_word(ImemAddr);
                lat_left = -1;
            end else begin
                ImemAck  = 1'b0;
                ImemData = $urandom;
                lat_left--;
            end
        end
        #1;
        if (RST) begin
            if (prev_req && !prev_ack) begin
                chk("req_hold", 32'(ImemReq), 32'd1);
                chk("addr_hold", ImemAddr, prev_addr);
            end
            if (!InsValid) begin
                chk("empty_ins", Ins, 32'd0);
                chk("empty_pc", InsPC, 32'd0);
                chk("empty_pcp4", PCPlus4, 32'd0);
            end else if (InsReady) begin
                chk("sb_pc", InsPC, exp_pc);
                chk("sb_ins", Ins, ref_word(exp_pc));
                chk("sb_pcp4", PCPlus4, exp_pc + 32'd4);
                delivered++;
                exp_pc = exp_pc + 32'd4;
            end
            if (Redirect) exp_pc = RedirectPC;
            if (InsValid_w && InsReady_w) begin
                chk("w_pc", InsPC_w, exp_w);
                chk("w_ins", Ins_w, ref_word(exp_w));
                chk("w_pcp4", PCPlus4_w, exp_w + 32'd4);
                exp_w = exp_w + 32'd4;
            end
            prev_req  = ImemReq;
            prev_ack  = ImemAck;
            prev_addr = ImemAddr;
        end
    endtask

    // Asserts reset between clock edges, holds it with acks forced on, then releases it.
    task automatic do_reset();
        RST          = 1'b0;
        ack_override = 1'b1;
        ImemAck      = 1'b1;
        ImemData     = 32'hDEAD_BEEF;
        #1;
        chk("rst_req", 32'(ImemReq), 32'd0);
        chk("rst_addr", ImemAddr, 32'd0);
        chk("rst_valid", 32'(InsValid), 32'd0);
        chk("rst_ins", Ins, 32'd0);
        chk("rst_pc", InsPC, 32'd0);
        chk("rst_pcp4", PCPlus4, 32'd0);
        chk("rst_w_req", 32'(ImemReq_w), 32'd0);
        repeat (3) begin
            cyc(1'b1, 1'b0, 32'd0);
            chk("rst_hold_req", 32'(ImemReq), 32'd0);
            chk("rst_hold_valid", 32'(InsValid), 32'd0);
        end
        RST          = 1'b1;
        ack_override = 1'b0;
        ImemAck      = 1'b0;
        lat_left     = -1;
        prev_req     = 1'b0;
        prev_ack     = 1'b0;
        exp_pc       = 32'h0000_0000;
        exp_w        = 32'hFFFF_FFF8;
    endtask

    initial begin
        RST = 1'b1; Redirect = 1'b0; RedirectPC = 32'd0; InsReady = 1'b1;
        ImemAck = 1'b0; ImemData = 32'd0; InsReady_w = 1'b1;
        prev_req = 1'b0; prev_ack = 1'b0; prev_addr = 32'd0;
        exp_pc = 32'd0; exp_w = 32'hFFFF_FFF8;
        @(negedge CLK);
        #1;
        do_reset();

        // Single-cycle memory, ID always ready: back-to-back fetch, plus the wrap instance.
        fixed_lat = 0;
        cyc(1'b1, 1'b0, 32'd0);
        chk("t1_c1_req", 32'(ImemReq), 32'd1);
        chk("t1_c1_addr", ImemAddr, 32'h0);
        chk("t1_c1_valid", 32'(InsValid), 32'd0);
        chk("t5_c1_addr", ImemAddr_w, 32'hFFFF_FFF8);
        cyc(1'b1, 1'b0, 32'd0);
        chk("t1_c2_addr", ImemAddr, 32'h4);
        chk("t1_c2_valid", 32'(InsValid), 32'd1);
        chk("t1_c2_pc", InsPC, 32'h0);
        chk("t1_c2_ins", Ins, ref_word(32'h0));
        chk("t1_c2_pcp4", PCPlus4, 32'h4);
        chk("t5_c2_addr", ImemAddr_w, 32'hFFFF_FFFC);
        cyc(1'b1, 1'b0, 32'd0);
        chk("t1_c3_addr", ImemAddr, 32'h8);
        chk("t1_c3_pc", InsPC, 32'h4);
        chk("t1_c3_pcp4", PCPlus4, 32'h8);
        chk("t5_c3_addr", ImemAddr_w, 32'h0);
        chk("t5_c3_pc", InsPC_w, 32'hFFFF_FFFC);
        chk("t5_c3_pcp4", PCPlus4_w, 32'h0);
        cyc(1'b1, 1'b0, 32'd0);
        chk("t1_c4_addr", ImemAddr, 32'hC);
        chk("t1_c4_pc", InsPC, 32'h8);
        chk("t1_c4_pcp4", PCPlus4, 32'hC);

        // ID stalled from the start: queue fills, fetch idles, then drains in order.
        do_reset();
        fixed_lat = 0;
        repeat (5) cyc(1'b0, 1'b0, 32'd0);
        chk("t2_req_idle", 32'(ImemReq), 32'd0);
        chk("t2_valid", 32'(InsValid), 32'd1);
        chk("t2_head_pc", InsPC, 32'h0);
        chk("t2_head_ins", Ins, ref_word(32'h0));
        d0 = delivered;
        repeat (10) cyc(1'b1, 1'b0, 32'd0);
        chk("t2_drain_count", 32'((delivered - d0) >= 6), 32'd1);

        // 3-cycle memory, redirect while the first request is outstanding.
        do_reset();
        fixed_lat = 2;
        cyc(1'b1, 1'b0, 32'd0);
        chk("t3_c1_addr", ImemAddr, 32'h0);
        cyc(1'b1, 1'b1, 32'h100);
        chk("t3_c2_ack", 32'(ImemAck), 32'd0);
        cyc(1'b1, 1'b0, 32'd0);
        chk("t3_c3_req", 32'(ImemReq), 32'd1);
        chk("t3_c3_addr", ImemAddr, 32'h0);
        chk("t3_c3_ack", 32'(ImemAck), 32'd1);
        cyc(1'b1, 1'b0, 32'd0);
        chk("t3_c4_addr", ImemAddr, 32'h100);
        chk("t3_c4_valid", 32'(InsValid), 32'd0);
        for (int i = 0; i < 10 && !InsValid; i++) cyc(1'b1, 1'b0, 32'd0);
        chk("t3_valid", 32'(InsValid), 32'd1);
        chk("t3_pc", InsPC, 32'h100);

        // Redirect coinciding with an ack and a transfer.
        do_reset();
        fixed_lat = 0;
        cyc(1'b1, 1'b0, 32'd0);
        cyc(1'b1, 1'b0, 32'd0);
        cyc(1'b1, 1'b1, 32'h200);
        chk("t4_pre_ack", 32'(ImemAck), 32'd1);
        chk("t4_pre_xfer", 32'(InsValid), 32'd1);
        chk("t4_pre_pc", InsPC, 32'h4);
        cyc(1'b1, 1'b0, 32'd0);
        chk("t4_flush_valid", 32'(InsValid), 32'd0);
        chk("t4_addr", ImemAddr, 32'h200);
        cyc(1'b1, 1'b0, 32'd0);
        chk("t4_valid", 32'(InsValid), 32'd1);
        chk("t4_pc", InsPC, 32'h200);

        // Reset asserted while a request is pending.
        fixed_lat = 2;
        cyc(1'b1, 1'b0, 32'd0);
        chk("t6_pre_req", 32'(ImemReq), 32'd1);
        chk("t6_pre_ack", 32'(ImemAck), 32'd0);
        do_reset();
        fixed_lat = 0;
        cyc(1'b1, 1'b0, 32'd0);
        chk("t6_addr", ImemAddr, 32'h0);
        chk("t6_req", 32'(ImemReq), 32'd1);
        cyc(1'b1, 1'b0, 32'd0);
        chk("t6_valid", 32'(InsValid), 32'd1);
        chk("t6_pc", InsPC, 32'h0);

        // Randomized latency, back-pressure, redirects and spurious acks.
        rand_mode = 1'b1;
        fixed_lat = -1;
        d0 = delivered;
        repeat (3000) begin
            rpc = $urandom & 32'hFFFF_FFFC;
            if (($urandom % 4) == 0) rpc = 32'hFFFF_FFF0 | (rpc & 32'hC);
            cyc(($urandom % 4) != 0, ($urandom % 20) == 0, rpc);
        end
        chk("rand_progress", 32'((delivered - d0) > 300), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
